// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, samples rows, and accepts a single key
// only after it is seen in DEBOUNCE_SCANS consecutive full scans. Release is debounced the same way.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] dbg_state_o
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      row_s1_q, row_s2_q;
    logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      col_n_q, col_n_d;
    logic [15:0]     snap_q, snap_d, snap_full;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic            slot_tick, scan_end;
    logic [4:0]      hits;
    logic [3:0]      hit_idx;
    logic            is_none, is_single;

    // Synchronizer idles at "no row pulled low" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
        end
    end

    assign slot_tick = (slot_cnt_q == SLOT_LAST);
    assign scan_end  = slot_tick && (col_idx_q == 2'd3);

    // The current column's rows are merged in so scan evaluation sees all 16 keys.
    always_comb begin
        snap_full = snap_q;
        for (int r = 0; r < 4; r++) begin
            snap_full[{2'(r), col_idx_q}] = ~row_s2_q[r];
        end
    end

    always_comb begin
        hits    = 5'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign is_none   = (hits == 5'd0);
    assign is_single = (hits == 5'd1);

    always_comb begin
        slot_cnt_d = slot_tick ? '0 : slot_cnt_q + SW'(1);
        col_idx_d  = slot_tick ? col_idx_q + 2'd1 : col_idx_q;
        col_n_d    = slot_tick ? ~(4'b0001 << col_idx_d) : col_n_q;
        snap_d     = snap_q;
        if (scan_end) begin
            snap_d = '0;
        end else if (slot_tick) begin
            snap_d = snap_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            col_idx_q  <= 2'd0;
            col_n_q    <= 4'b1110;
            snap_q     <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            col_idx_q  <= col_idx_d;
            col_n_q    <= col_n_d;
            snap_q     <= snap_d;
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (scan_end) begin
            unique case (state_q)
                IDLE: begin
                    if (is_single) begin
                        cand_d  = hit_idx;
                        cnt_d   = CW'(1);
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (is_single && (hit_idx == cand_q)) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        cnt_d   = CW'(1);
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n       = col_n_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scan).
// Step counts below are cycles since reset release; scan ends fall on multiples of 16.
module tb_keypad_scanner;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [1:0]  dbg_state;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  exp_col;

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .dbg_state_o (dbg_state)
    );

    // Keypad model: a pressed key (r,c) pulls row r low while column c is strobed.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) valid_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_col", col_n, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        check("rst_code", key_code, 4'd0);
        check("rst_state", dbg_state, S_IDLE);
        for (int k = 1; k <= 4; k++) begin
            step(4);
            exp_col = ~(4'b0001 << (k % 4));
            check("scan_col", col_n, exp_col);
        end

        // bounce: key 0 seen in one scan only
        keys = 16'h0001;
        step(16);
        keys = 16'h0000;
        step(1);
        check("bounce_deb", dbg_state, S_DEB);
        step(15);
        check("bounce_idle", dbg_state, S_IDLE);
        step(16);
        check("bounce_pulses", valid_cnt, 0);
        check("bounce_held", key_held, 1'b0);
        check("bounce_code", key_code, 4'd0);

        // clean press of key 6 (row1,col2), T=64
        keys = 16'h0040;
        step(47);
        check("press_pre_valid", key_valid, 1'b0);
        check("press_pre_held", key_held, 1'b0);
        step(1);
        check("press_valid", key_valid, 1'b1);
        check("press_code", key_code, 4'd6);
        check("press_held", key_held, 1'b1);
        step(1);
        check("press_valid_fall", key_valid, 1'b0);
        check("press_pulses", valid_cnt, 1);
        step(47);
        check("press_hold_pulses", valid_cnt, 1);
        check("press_hold_state", dbg_state, S_HELD);

        // short release then re-press, T=160
        keys = 16'h0000;
        step(16);
        check("rel_state", dbg_state, S_REL);
        check("rel_held", key_held, 1'b1);
        keys = 16'h0040;
        step(16);
        check("repress_state", dbg_state, S_HELD);
        check("repress_held", key_held, 1'b1);
        keys = 16'h0000;
        step(47);
        check("rel_pre_held", key_held, 1'b1);
        step(1);
        check("rel_done_held", key_held, 1'b0);
        check("rel_done_code", key_code, 4'd6);
        check("rel_done_state", dbg_state, S_IDLE);
        check("rel_done_pulses", valid_cnt, 1);
        keys = 16'h0040;
        step(48);
        check("press2_valid", key_valid, 1'b1);
        check("press2_code", key_code, 4'd6);
        step(16);
        check("press2_pulses", valid_cnt, 2);
        keys = 16'h0000;
        step(48);
        check("press2_released", key_held, 1'b0);

        // two keys at once, T=352
        keys = 16'h8200;
        step(80);
        check("multi_pulses", valid_cnt, 2);
        check("multi_held", key_held, 1'b0);
        check("multi_state", dbg_state, S_IDLE);
        keys = 16'h0200;
        step(48);
        check("single9_valid", key_valid, 1'b1);
        check("single9_code", key_code, 4'd9);
        check("single9_held", key_held, 1'b1);
        step(1);
        check("single9_pulses", valid_cnt, 3);
        step(15);
        keys = 16'h0000;
        step(48);
        check("single9_released", key_held, 1'b0);

        // reset during debounce of key 15, T=544
        keys = 16'h8000;
        step(32);
        check("mid_state", dbg_state, S_DEB);
        rst_n = 1'b0;
        #1;
        check("mid_rst_code", key_code, 4'd0);
        check("mid_rst_held", key_held, 1'b0);
        check("mid_rst_state", dbg_state, S_IDLE);
        check("mid_rst_col", col_n, 4'b1110);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_exit_valid", key_valid, 1'b0);
        check("mid_exit_code", key_code, 4'd0);
        step(47);
        check("mid_pre_valid", key_valid, 1'b0);
        check("mid_pre_pulses", valid_cnt, 3);
        step(1);
        check("mid_valid", key_valid, 1'b1);
        check("mid_code", key_code, 4'd15);
        check("mid_held", key_held, 1'b1);
        step(1);
        check("mid_pulses", valid_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
